// File: rtl/decoder_pkg.sv
// Shared definitions for the binary-to-one-hot decoder pipe.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
package decoder_pkg;

   // Default width of the saturating delivery counters
   localparam int CNT_W_DEFAULT = 16;

   // Buffer occupancy encodings
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // Legal parameter set: at least two outputs, and the code must be wide
   // enough to address every output line
   function automatic bit params_ok(input int n_out, input int w_in);
      return (n_out >= 2) && (w_in >= $clog2(n_out));
   endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Generic 2-entry valid/ready buffer; owns occupancy, in_ready and out_valid.
// Latency: 1 cycle from accept to out_valid; 1 transfer/cycle sustained.
// Backpressure: in_ready is registered (occ != FULL), no comb path from out_ready_i.
module decoder_skid_buf
   import decoder_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_dat_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_dat_o
);

   occ_e             occ_q, occ_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             in_ready_q, out_valid_q;
   logic             push, pop;

   assign push        = in_valid_i & in_ready_q;
   assign pop         = out_valid_q & out_ready_i;
   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_dat_o   = head_q;

   // Next occupancy and entry contents; head is always the oldest entry
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (push) begin
               head_d = in_dat_i;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (push && pop) begin
               head_d = in_dat_i;
            end else if (push) begin
               tail_d = in_dat_i;
               occ_d  = OCC_FULL;
            end else if (pop) begin
               occ_d  = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            // in_ready is low here, so only a pop can happen
            if (pop) begin
               head_d = tail_q;
               occ_d  = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   // State registers; flags are registered from the next occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q       <= OCC_EMPTY;
         head_q      <= '0;
         tail_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         occ_q       <= occ_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         in_ready_q  <= (occ_d != OCC_FULL);
         out_valid_q <= (occ_d != OCC_EMPTY);
      end
   end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder with error flag and delivery counters.
// Latency: 1 cycle accept-to-output; full throughput with out_ready held high.
// Backpressure: 2-entry buffer; in_ready drops only when both entries are held.
module onehot_decoder_pipe
   import decoder_pkg::*;
#(
   parameter int N_OUT = 4,
   parameter int W_IN  = 2,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_code,
   input  logic             in_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_OUT-1:0] out_y,
   output logic             out_err,
   output logic [CNT_W-1:0] dec_count,
   output logic [CNT_W-1:0] err_count
);

   generate
      if (!params_ok(N_OUT, W_IN)) begin : g_bad_params
         $error("onehot_decoder_pipe: illegal N_OUT/W_IN combination");
      end
   endgenerate

   // N_OUT always fits in W_IN+1 bits given a legal W_IN
   localparam logic [W_IN:0] N_OUT_C = (W_IN + 1)'(N_OUT);

   logic [N_OUT-1:0] dec_y;
   logic             dec_err;
   logic [N_OUT:0]   buf_out_dat;
   logic [CNT_W-1:0] dec_count_q, err_count_q;
   logic             deliver;

   // Decode in front of the buffer so entries hold {y, err}, not the raw code
   always_comb begin
      dec_y   = '0;
      dec_err = in_en && ({1'b0, in_code} >= N_OUT_C);
      for (int i = 0; i < N_OUT; i++) begin
         dec_y[i] = in_en && (in_code == W_IN'(i));
      end
   end

   decoder_skid_buf #(
      .WIDTH(N_OUT + 1)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_dat_i   ({dec_err, dec_y}),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_dat_o  (buf_out_dat)
   );

   assign out_y     = buf_out_dat[N_OUT-1:0];
   assign out_err   = buf_out_dat[N_OUT];
   assign deliver   = out_valid & out_ready;
   assign dec_count = dec_count_q;
   assign err_count = err_count_q;

   // Saturating counters, stepped on delivery only
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_count_q <= '0;
         err_count_q <= '0;
      end else if (deliver) begin
         if (out_err) begin
            if (err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
         end else begin
            if (dec_count_q != '1) dec_count_q <= dec_count_q + CNT_W'(1);
         end
      end
   end

endmodule
